// File: rtl/dma_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dma_ctrl_pkg
// Shared definitions for the DMA control/status register block:
//   - register offsets (word index, wbs_adr_i[3:2])
//   - CTRL / STATUS bit positions
//   - sequencing FSM state encoding
// -----------------------------------------------------------------------------
package dma_ctrl_pkg;

  // Word index of each register within the 16-byte window.
  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_TIMEOUT = 2'd2;
  localparam logic [1:0] REG_COUNT   = 2'd3;

  // CTRL bits.
  localparam int CTRL_START  = 0;
  localparam int CTRL_HALT   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_TMO  = 2;
  localparam int STAT_ERR  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    WAIT  = 3'd2,
    RUN   = 3'd3,
    ABORT = 3'd4
  } state_e;

endpackage

// File: rtl/dma_ctrl_regs_if.sv
// -----------------------------------------------------------------------------
// dma_ctrl_regs_if
// Wishbone slave bus bundle for dma_ctrl_regs.
//   wbs_cyc_i, wbs_stb_i, wbs_we_i : cycle, strobe, write
//   wbs_sel_i [3:0]                : byte enables
//   wbs_adr_i [31:0]               : byte address
//   wbs_dat_i [31:0]               : write data
//   wbs_ack_o                      : registered acknowledge
//   wbs_dat_o [31:0]               : registered read data
// Signal suffixes are from the slave's point of view.
// -----------------------------------------------------------------------------
interface dma_ctrl_regs_if;

  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/dma_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// dma_ctrl_watchdog
// Cycle counter that flags a transfer running for TIMEOUT cycles.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : force the counter to 0 (held while not running)
//   en_i      : count this cycle
//   limit_i   : limit in cycles; 0 disables expiry
//   expire_o  : asserted during the limit-th counting cycle
// -----------------------------------------------------------------------------
module dma_ctrl_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 en_i,
  input  logic [TIMEOUT_W-1:0] limit_i,
  output logic                 expire_o
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)   cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Counter starts at 0 on the first running cycle, so matching limit-1
  // fires on exactly the limit-th cycle.
  assign expire_o = en_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);

endmodule

// File: rtl/dma_ctrl_regs.sv
// -----------------------------------------------------------------------------
// dma_ctrl_regs
// Wishbone-slave control/status block in front of the DMA memory engine.
// Sequences start/run/complete, counts completions, keeps sticky status and
// drives one maskable level interrupt.
//
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   wbs                : Wishbone slave bundle (dma_ctrl_regs_if.slave)
//   dma_start_o        : one-cycle start pulse to the engine
//   dma_halt_o         : halt level to the engine
//   dma_busy_i         : engine busy
//   dma_done_i         : engine done pulse
//   irq_o              : interrupt (level)
//
// Build option DMA_CTRL_TIMEOUT_EN: adds the watchdog, the TIMEOUT register,
// the TMO status bit and the ABORT path. Without it TIMEOUT and TMO read 0.
// -----------------------------------------------------------------------------
module dma_ctrl_regs
  import dma_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT_W = 24,
  parameter int          CNT_W     = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  dma_ctrl_regs_if.slave wbs,
  output logic           dma_start_o,
  output logic           dma_halt_o,
  input  logic           dma_busy_i,
  input  logic           dma_done_i,
  output logic           irq_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic               halt_q, halt_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TIMEOUT_W-1:0] timeout_val;

  // ---------------------------------------------------------------------------
  // Bus decode. ack_q blocks a second access while the first is being acked,
  // which gives one ack every two cycles for back-to-back strobes.
  // ---------------------------------------------------------------------------
  logic       addr_hit, access, wr;
  logic [1:0] reg_sel;
  logic       ctrl_wr, status_wr, start_req;

  assign addr_hit  = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign access    = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q && addr_hit;
  assign wr        = access && wbs.wbs_we_i;
  assign reg_sel   = wbs.wbs_adr_i[3:2];
  assign ctrl_wr   = wr && (reg_sel == REG_CTRL)   && wbs.wbs_sel_i[0];
  assign status_wr = wr && (reg_sel == REG_STATUS) && wbs.wbs_sel_i[0];
  assign start_req = ctrl_wr && wbs.wbs_dat_i[CTRL_START];

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  logic wd_expire;

`ifdef DMA_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [31:0]          timeout_word;

  always_comb begin
    timeout_word = 32'(timeout_q);
    if (wr && (reg_sel == REG_TIMEOUT)) begin
      for (int b = 0; b < 4; b++) begin
        if (wbs.wbs_sel_i[b]) timeout_word[b*8 +: 8] = wbs.wbs_dat_i[b*8 +: 8];
      end
    end
    timeout_d = timeout_word[TIMEOUT_W-1:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) timeout_q <= '0;
    else          timeout_q <= timeout_d;
  end

  assign timeout_val = timeout_q;

  // Held clear outside RUN, so the count is 0 on the first RUN cycle.
  dma_ctrl_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_watchdog (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .clear_i  (state_q != RUN),
    .en_i     (state_q == RUN),
    .limit_i  (timeout_q),
    .expire_o (wd_expire)
  );
`else
  assign timeout_val = '0;
  assign wd_expire   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Sequencing FSM: next state and FSM-owned outputs
  // ---------------------------------------------------------------------------
  logic complete, tmo_hit, in_abort;

  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    dma_start_o = 1'b0;
    complete    = 1'b0;
    tmo_hit     = 1'b0;
    in_abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) state_d = PULSE;
      end
      PULSE: begin
        dma_start_o = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        // A transfer short enough to finish before busy is seen.
        if (dma_done_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (dma_busy_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (dma_done_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (wd_expire) begin
          tmo_hit = 1'b1;
          state_d = ABORT;
        end
      end
      ABORT: begin
        in_abort = 1'b1;
        if (!dma_busy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file next state
  // ---------------------------------------------------------------------------
  logic        start_err;
  logic [31:0] rd_data;

  assign start_err = start_req && (state_q != IDLE);

  always_comb begin
    halt_d   = halt_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) begin
      halt_d   = wbs.wbs_dat_i[CTRL_HALT];
      irq_en_d = wbs.wbs_dat_i[CTRL_IRQ_EN];
    end

    // Sticky W1C bits: the clear is applied first so a same-edge hardware
    // set wins.
    done_d = done_q;
    tmo_d  = tmo_q;
    err_d  = err_q;
    if (status_wr) begin
      if (wbs.wbs_dat_i[STAT_DONE]) done_d = 1'b0;
      if (wbs.wbs_dat_i[STAT_TMO])  tmo_d  = 1'b0;
      if (wbs.wbs_dat_i[STAT_ERR])  err_d  = 1'b0;
    end
    if (complete)  done_d = 1'b1;
    if (tmo_hit)   tmo_d  = 1'b1;
    if (start_err) err_d  = 1'b1;

    count_d = count_q + CNT_W'(complete);

    rd_data = '0;
    unique case (reg_sel)
      REG_CTRL: begin
        rd_data[CTRL_HALT]   = halt_q;
        rd_data[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS: begin
        rd_data[STAT_BUSY] = dma_busy_i;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_TMO]  = tmo_q;
        rd_data[STAT_ERR]  = err_q;
      end
      REG_TIMEOUT: rd_data = 32'(timeout_val);
      REG_COUNT:   rd_data = 32'(count_q);
      default:     rd_data = '0;
    endcase

    ack_d = access;
    dat_d = access ? rd_data : dat_q;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values computed above.
  // NOTE: all flops reset synchronously here; the block holds no memory
  // arrays, so nothing is left unreset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      halt_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      halt_q   <= halt_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign dma_halt_o    = halt_q || in_abort;
  assign irq_o         = irq_en_q && (done_q || tmo_q || err_q);

  // Address byte offset and, in the default build, upper data bits are
  // intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i, wbs.wbs_sel_i};

endmodule

// File: tb/tb_dma_ctrl_regs.sv
// -----------------------------------------------------------------------------
// tb_dma_ctrl_regs
// Directed self-checking bench for dma_ctrl_regs. Inputs are driven and
// outputs sampled on the falling clock edge. The watchdog scenarios compile
// only when DMA_CTRL_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_dma_ctrl_regs;
  import dma_ctrl_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic done = 1'b0;
  logic start, halt, irq;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  dma_ctrl_regs_if wbs ();

  dma_ctrl_regs dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (wbs),
    .dma_start_o (start),
    .dma_halt_o  (halt),
    .dma_busy_i  (busy),
    .dma_done_i  (done),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  // Counts cycles in which the start pulse was high.
  always @(posedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                         input logic [31:0] wdat, output logic [31:0] rdat);
    int lat;
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_sel_i = sel;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = wdat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wbs.wbs_ack_o && lat < 8);
    rdat = wbs.wbs_dat_o;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    check("ack_latency", 32'(lat), 32'd1);
  endtask

  task automatic wb_wr(input logic [3:0] off, input logic [31:0] data,
                       input logic [3:0] sel = 4'hF);
    logic [31:0] dummy;
    wb_xfer(BASE + 32'(off), 1'b1, sel, data, dummy);
  endtask

  task automatic wb_rd(input logic [3:0] off, output logic [31:0] data);
    wb_xfer(BASE + 32'(off), 1'b0, 4'hF, 32'h0, data);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst  = 1'b1;
    busy = 1'b0;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle done pulse with busy dropped.
  task automatic done_pulse();
    busy = 1'b0;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          base_starts;
    int          acks;

    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = 32'h0;
    wbs.wbs_dat_i = 32'h0;

    // ---- Reset state and register reads --------------------------------
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack",   32'(wbs.wbs_ack_o), 32'd0);
    check("rst_dat",   wbs.wbs_dat_o,      32'd0);
    check("rst_start", 32'(start),         32'd0);
    check("rst_halt",  32'(halt),          32'd0);
    check("rst_irq",   32'(irq),           32'd0);
    for (int i = 0; i < 4; i++) begin
      wb_rd(4'(i * 4), rd);
      check("rst_read", rd, 32'd0);
      @(negedge clk);
      check("ack_one_cycle", 32'(wbs.wbs_ack_o), 32'd0);
    end

    // ---- Normal transfer with interrupt ----------------------------------
    base_starts = start_cnt;
    wb_wr(4'h0, 32'h5);
    check("start_high", 32'(start), 32'd1);
    @(negedge clk);
    check("start_low", 32'(start), 32'd0);
    busy = 1'b1;
    repeat (10) @(negedge clk);
    done_pulse();
    check("one_start", 32'(start_cnt - base_starts), 32'd1);
    wb_rd(4'hC, rd); check("count_1", rd, 32'd1);
    wb_rd(4'h4, rd); check("status_done", rd, 32'h2);
    wb_rd(4'h0, rd); check("ctrl_read", rd, 32'h4);
    check("irq_set", 32'(irq), 32'd1);
    wb_wr(4'h4, 32'h2);
    check("irq_clr", 32'(irq), 32'd0);
    wb_rd(4'h4, rd); check("status_w1c", rd, 32'h0);

    // ---- START while running ---------------------------------------------
    reset_dut();
    base_starts = start_cnt;
    wb_wr(4'h0, 32'h1);
    @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    wb_rd(4'h4, rd); check("status_busy", rd, 32'h1);
    wb_wr(4'h0, 32'h1);
    wb_rd(4'h4, rd); check("status_err", rd, 32'h9);
    done_pulse();
    check("no_restart", 32'(start_cnt - base_starts), 32'd1);
    wb_rd(4'hC, rd); check("count_err_run", rd, 32'd1);
    wb_rd(4'h4, rd); check("status_done_err", rd, 32'hA);
    check("irq_masked", 32'(irq), 32'd0);
    wb_wr(4'h0, 32'h4);
    check("irq_unmasked", 32'(irq), 32'd1);
    wb_wr(4'h4, 32'h8);
    wb_rd(4'h4, rd); check("w1c_err_only", rd, 32'h2);

    // ---- Byte enables and address decode ---------------------------------
    reset_dut();
    wb_wr(4'h0, 32'h6, 4'hE);
    wb_rd(4'h0, rd); check("ctrl_sel0_only", rd, 32'h0);
    wb_wr(4'h8, 32'h1234_5678);
`ifdef DMA_CTRL_TIMEOUT_EN
    wb_rd(4'h8, rd); check("timeout_rw", rd, 32'h0034_5678);
    wb_wr(4'h8, 32'hAABB_CCDD, 4'b0010);
    wb_rd(4'h8, rd); check("timeout_lane1", rd, 32'h0034_CC78);
    wb_wr(4'h8, 32'h0);
`else
    wb_rd(4'h8, rd); check("timeout_absent", rd, 32'h0);
`endif
    @(negedge clk);
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = 1'b1;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = BASE + 32'h10;
    wbs.wbs_dat_i = 32'h7;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wbs.wbs_ack_o) acks++;
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    check("miss_no_ack", 32'(acks), 32'd0);
    check("miss_no_start", 32'(start), 32'd0);
    wb_rd(4'h0, rd); check("miss_no_effect", rd, 32'h0);

`ifdef DMA_CTRL_TIMEOUT_EN
    // ---- Watchdog expiry ---------------------------------------------------
    reset_dut();
    wb_wr(4'h8, 32'd8);
    wb_wr(4'h0, 32'h1);
    @(negedge clk);
    busy = 1'b1;
    repeat (8) @(negedge clk);
    check("wd_not_yet", 32'(halt), 32'd0);
    @(negedge clk);
    check("wd_halt", 32'(halt), 32'd1);
    wb_rd(4'h4, rd); check("status_tmo", rd, 32'h5);
    check("wd_halt_hold", 32'(halt), 32'd1);
    busy = 1'b0;
    @(negedge clk);
    check("abort_release", 32'(halt), 32'd0);
    check("abort_idle", 32'(dut.state_q), 32'(IDLE));
    wb_rd(4'hC, rd); check("count_no_tmo", rd, 32'd0);

    // ---- Done on the expiry cycle ------------------------------------------
    reset_dut();
    wb_wr(4'h8, 32'd3);
    wb_wr(4'h0, 32'h1);
    @(negedge clk);
    busy = 1'b1;
    repeat (3) @(negedge clk);
    done_pulse();
    check("race_idle", 32'(dut.state_q), 32'(IDLE));
    check("race_no_halt", 32'(halt), 32'd0);
    wb_rd(4'h4, rd); check("race_status", rd, 32'h2);
    wb_rd(4'hC, rd); check("race_count", rd, 32'd1);
`endif

    // ---- Reset mid-transfer ------------------------------------------------
    reset_dut();
    busy = 1'b1;
    wb_wr(4'h0, 32'h7);
    wb_wr(4'h0, 32'h7);
    wb_rd(4'h0, rd); check("pre_rst_ctrl", rd, 32'h6);
    check("pre_rst_halt", 32'(halt), 32'd1);
    check("pre_rst_irq", 32'(irq), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack",   32'(wbs.wbs_ack_o), 32'd0);
    check("mid_rst_dat",   wbs.wbs_dat_o,      32'd0);
    check("mid_rst_start", 32'(start),         32'd0);
    check("mid_rst_halt",  32'(halt),          32'd0);
    check("mid_rst_irq",   32'(irq),           32'd0);
    check("mid_rst_state", 32'(dut.state_q),   32'(IDLE));
    rst  = 1'b0;
    busy = 1'b0;

    // ---- COUNT wrap ---------------------------------------------------------
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    wb_rd(4'hC, rd); check("count_max", rd, 32'h0000_FFFF);
    wb_wr(4'h0, 32'h1);
    @(negedge clk);
    done_pulse();
    wb_rd(4'hC, rd); check("count_wrap", rd, 32'h0);
    wb_rd(4'h4, rd); check("wrap_status", rd, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
